// File: rtl/mux_sweep_pkg.sv
// Shared types for the exhaustive 2:1 select-stage sweep checker.
// Optional MUX_SWEEP_LOG_EN enables per-vector simulation logging in the top.
package mux_sweep_pkg;

  localparam int MAX_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic int lat_w(input int lat);
    return (lat > 1) ? $clog2(lat + 1) : 1;
  endfunction

endpackage

// File: rtl/mux_sweep_ref.sv
// Golden model of the bitwise select stage: exp = c ? b : a.
module mux_sweep_ref #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] exp_o
);

  assign exp_o = c_i ? b_i : a_i;

endmodule

// File: rtl/mux_sweep_checker.sv
// Sweeps all a/b/c combinations into a select stage and scores its z output.
// Define MUX_SWEEP_LOG_EN to print every compare and the sweep summary.
module mux_sweep_checker
  import mux_sweep_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int LAT   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     z_i,
  output logic [WIDTH-1:0]     a_o,
  output logic [WIDTH-1:0]     b_o,
  output logic                 c_o,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH+1:0]   pass_cnt,
  output logic [2*WIDTH+1:0]   fail_cnt,
  output logic [2*WIDTH:0]     first_fail_vec,
  output logic                 first_fail_valid
);

  localparam int NV    = 2 ** (2 * WIDTH + 1);
  localparam int CNT_W = 2 * WIDTH + 2;
  localparam int VW    = 2 * WIDTH + 1;
  localparam int LW    = lat_w(LAT);

  localparam logic [LW-1:0] LAT_L  = LW'(LAT);
  localparam logic [VW-1:0] V_LAST = VW'(NV - 1);

  state_e             state_q, state_d;
  logic [VW-1:0]      v_q, v_d;
  logic [LW-1:0]      wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic [VW-1:0]      ffv_q, ffv_d;
  logic               ffval_q, ffval_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   exp_w;
  logic               hit;

  assign c_o = v_q[0];
  assign b_o = v_q[WIDTH:1];
  assign a_o = v_q[2*WIDTH:WIDTH+1];

  mux_sweep_ref #(
    .WIDTH (WIDTH)
  ) u_ref (
    .a_i   (a_o),
    .b_i   (b_o),
    .c_i   (c_o),
    .exp_o (exp_w)
  );

  // X or Z on z_i must score as a failure
  assign hit = (z_i === exp_w);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    wcnt_d  = wcnt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pass_d  = '0;
          fail_d  = '0;
          ffv_d   = '0;
          ffval_d = 1'b0;
          v_d     = '0;
          wcnt_d  = LAT_L;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - LW'(1);
        end else begin
          if (hit) begin
            pass_d = pass_q + CNT_W'(1);
          end else begin
            fail_d = fail_q + CNT_W'(1);
            if (!ffval_q) begin
              ffv_d   = v_q;
              ffval_d = 1'b1;
            end
          end
          if (v_q == V_LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            v_d    = v_q + VW'(1);
            wcnt_d = LAT_L;
          end
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_q     <= '0;
      wcnt_q  <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      wcnt_q  <= wcnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign pass_cnt         = pass_q;
  assign fail_cnt         = fail_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;

`ifdef MUX_SWEEP_LOG_EN
  always @(posedge clk) begin
    if (rst_n && state_q == SETTLE && wcnt_q == '0) begin
      if (hit)
        $display("PASS: a=%b b=%b c=%b z=%b", a_o, b_o, c_o, z_i);
      else
        $display("FAIL: a=%b b=%b c=%b z=%b", a_o, b_o, c_o, z_i);
    end
    if (rst_n && state_q == DONE)
      $display("SWEEP DONE pass=%0d fail=%0d", pass_q, fail_q);
  end
`endif

endmodule

// File: doc/mux_sweep_checker.md
Name: mux_sweep_checker

Overview:
- Sequential stimulus generator and self-checker for the bitwise 2:1 select stage z = (a & ~c) | (b & c).
- Sits directly upstream of the mux, driving a/b/c, and downstream of it, consuming z.
- Sweeps every input combination in nested-loop order (a outer, b middle, c inner), waits a programmable DUT latency, compares z against a golden model, and accumulates pass/fail statistics.
- Replaces the hand-written exhaustive loop benches with a reusable clocked block.

Parameters:
WIDTH, 1, data width of a, b, z; legal range 1..4
LAT, 0, DUT latency in clock cycles (0 = combinational DUT)
NV (localparam), 2**(2*WIDTH+1), number of vectors in one sweep
CNT_W (localparam), 2*WIDTH+2, counter width; holds the value NV

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE
z_i  input  WIDTH  DUT output under test
a_o  output  WIDTH  stimulus a
b_o  output  WIDTH  stimulus b
c_o  output  1  stimulus select c
busy  output  1  sweep in progress
done  output  1  one-cycle pulse at end of sweep
pass_cnt  output  CNT_W  vectors matching the golden model
fail_cnt  output  CNT_W  vectors mismatching the golden model
first_fail_vec  output  2*WIDTH+1  index of the first failing vector
first_fail_valid  output  1  first_fail_vec holds a captured index

Behaviour:
- One clock. Reset is asynchronous and active-low (clk, rst_n).
- Reset: all outputs 0, state IDLE, vector index v = 0, wait counter = 0.
- Vector decode: c_o = v[0], b_o = v[WIDTH:1], a_o = v[2*WIDTH:WIDTH+1]. Consecutive v reproduces the a-outer, b, c-inner loop order.
- Stimulus outputs are registered directly from v.
- Golden model: exp = c_o ? b_o : a_o, bitwise.
- Comparison uses case equality, so any X or Z on z_i counts as a fail.
- States: IDLE, SETTLE, DONE.
- IDLE: on start=1,
  - clear pass_cnt, fail_cnt, first_fail_vec, first_fail_valid;
  - v = 0, wait counter = LAT;
  - busy = 1; go to SETTLE.
  - Vector 0 appears on a_o/b_o/c_o at this same edge.
- SETTLE, wait counter != 0: decrement it.
- SETTLE, wait counter == 0: sample z_i and compare.
  - Match: pass_cnt += 1.
  - Mismatch: fail_cnt += 1. If first_fail_valid == 0, capture v into first_fail_vec and set first_fail_valid.
  - v == NV-1: go to DONE.
  - Otherwise: v += 1, reload wait counter = LAT, stay in SETTLE.
- Timing: each vector is held exactly LAT+1 cycles; z_i is sampled on the last of them. busy is high for NV*(LAT+1) cycles.
- DONE: done = 1 and busy = 0 for exactly one cycle, then IDLE.
  - Counters and first-fail capture hold until the next start.
  - a_o/b_o/c_o hold the last vector.
- start while busy (SETTLE or DONE): ignored.
- start held high: a new sweep begins on the first IDLE cycle after DONE.
- Reset mid-sweep: immediate return to reset values; the partial results are discarded.
- Counters cannot overflow: maximum value is NV, which fits in CNT_W bits.
- pass_cnt + fail_cnt == NV whenever done = 1.

Optional Feature:
MUX_SWEEP_LOG_EN
- Defined: at each compare, prints via $display
  "PASS: a=%b b=%b c=%b z=%b" or "FAIL: a=%b b=%b c=%b z=%b"
  using the current a_o, b_o, c_o, z_i; prints "SWEEP DONE pass=%0d fail=%0d" at DONE. Simulation only; no effect on ports or timing.
- Undefined: no display code is compiled; behaviour is otherwise identical.

Decomposition:
- Package mux_sweep_pkg: state enum (IDLE, SETTLE, DONE); maximum-WIDTH constant (4).
- One sub-module, mux_sweep_ref: combinational golden model, exp = c ? b : a, parameterised by WIDTH. Instantiated once by mux_sweep_checker.

Test Plan:
1. WIDTH=1, LAT=0, correct mux on z_i; pulse start -> busy high 8 cycles; done pulses; pass_cnt=8, fail_cnt=0, first_fail_valid=0.
2. WIDTH=1, LAT=0, z_i tied 0 -> pass_cnt=4, fail_cnt=4, first_fail_vec=3'b011 (a=0 b=1 c=1), first_fail_valid=1.
3. WIDTH=1, LAT=2, correct mux followed by 2 register stages -> busy high 24 cycles; pass_cnt=8, fail_cnt=0. The same DUT with LAT=0 -> fail_cnt>0.
4. Assert rst_n low after 3 vectors -> all outputs 0 asynchronously; a following start gives pass_cnt=8, fail_cnt=0.
5. Pulse start during SETTLE -> ignored, single done pulse. Hold start high -> the second sweep's vector 0 appears 1 cycle after done.
6. WIDTH=4, LAT=0, correct mux -> 512 vectors; pass_cnt=512 (10-bit), fail_cnt=0; with MUX_SWEEP_LOG_EN defined, 512 PASS lines plus the summary line.
